count_sseg_driver: RTL
======================

Name: count_sseg_driver

Overview:
- Downstream display stage for the free-running 4-bit counter.
- Takes the 4-bit count (0-15), converts it to two decimal digits, and time-multiplexes them onto a common-anode two-digit 7-segment display.
- Snapshots the count once per display frame so a digit pair never tears mid-frame.
- Runs entirely on the board clock, with an inter-digit blanking window to suppress ghosting.

Parameters:
- REFRESH_BITS, 16: width of the refresh counter; each digit is held for 2^REFRESH_BITS clk cycles.
- BLANK_CYCLES, 64: clk cycles at the start of each digit period with both anodes off. Must be less than 2^REFRESH_BITS.
- BLANK_LEADING_ZERO, 1: when 1, the tens digit is dark while the value is below 10.

Ports:
- clk  input  1  board clock; all logic is on its rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- count  input  4  binary count from the counter stage. Its timing is unrelated to the frame, so it is synchronised internally.
- seg  output  7  active-low segments {g,f,e,d,c,b,a}.
- an  output  2  active-low anodes. an[0] = ones digit, an[1] = tens digit.
- dp  output  1  active-low decimal point. Held at 1 (off) at all times.

Behaviour:
- Reset: rst low asynchronously forces the following:
  - sync flops, snapshot register disp_val, ref_cnt and digit_sel all to 0;
  - an = 2'b11, seg = 7'b1111111, dp = 1.
  - Reset mid-frame abandons the frame; after release, the first frame starts at ref_cnt = 0 with the ones digit.
- Input sync: count passes through two flops (sync1, sync2) before any use.
- Refresh counter:
  - ref_cnt increments by 1 every clk and wraps from all-ones to 0.
  - On the edge where ref_cnt == all-ones, digit_sel toggles. digit_sel 0 = ones, 1 = tens.
- Frame snapshot: on the edge where ref_cnt == all-ones and digit_sel == 1 (end of the tens period), disp_val <= sync2. disp_val is otherwise held.
- Decode (combinational from disp_val):
  - tens = (disp_val >= 10) ? 1 : 0.
  - ones = (disp_val >= 10) ? disp_val - 10 : disp_val, 4-bit result.
- Segment table (active-low, g..a):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
- Output register: seg and an are registered from the current ref_cnt, digit_sel and disp_val, so they lag internal state by exactly one clk.
  - While ref_cnt < BLANK_CYCLES: an = 2'b11. seg still shows the selected digit's pattern.
  - Otherwise, digit_sel 0: an = 2'b10, seg = pattern(ones).
  - Otherwise, digit_sel 1: if BLANK_LEADING_ZERO == 1 and tens == 0, an = 2'b11 and seg = 1111111; else an = 2'b01 and seg = pattern(tens).
- Latency: a new count becomes visible at the first frame boundary occurring at least 2 clk after the change, plus 1 clk output delay. Worst case is about 2*2^REFRESH_BITS + 3 clk.
- Count changes more than once within a frame: only the value present in sync2 at the snapshot edge is shown. Intermediate values are dropped by design.
- Wrap 15 -> 0: the display goes from "15" to " 0" (or "00" when BLANK_LEADING_ZERO = 0) at a frame boundary, with no mixed digits.
- an is never 2'b00. Both digits are never driven simultaneously, including across the digit_sel toggle.

Test Plan:
- Reset check (REFRESH_BITS=4, BLANK_CYCLES=2): assert rst=0 mid-frame. Required: an=11, seg=1111111, dp=1 immediately, without waiting for a clk edge. Release rst: ones period starts at ref_cnt=0.
- Single-digit value: count=7, run 2 frames. Required: ones period has an=10, seg=1111000 after blanking. Tens period has an=11 (BLANK_LEADING_ZERO=1). With BLANK_LEADING_ZERO=0, tens period has an=01, seg=1000000.
- Two-digit value: count=13. Required: ones period an=10, seg=0110000; tens period an=01, seg=1111001.
- Tear-free update: hold count=9, then change it to 10 in the middle of a ones period. Required: that frame's tens period still shows blank. The next frame shows ones seg=1000000 and tens seg=1111001, with no mixed "19".
- Blanking and anode safety: sample every clk over 4 frames. Required: an=11 for exactly BLANK_CYCLES cycles after each digit_sel toggle (offset by 1 clk), and an never equals 00.
- Wrap: step count 14, 15, 0, one value per frame. Required: displays "14", "15", " 0" on successive frames, and seg always matches the table.

Source files
------------

// File: rtl/count_sseg_driver.sv
// count_sseg_driver
// Display stage for a free-running 4-bit counter. The count is synchronised,
// snapshotted once per display frame and shown as two decimal digits on a
// common-anode, time-multiplexed 7-segment display. Every digit period begins
// with a short window where both anodes are off, which suppresses ghosting.
// All outputs are active-low.

module count_sseg_driver #(
  parameter int REFRESH_BITS       = 16,  // each digit is held 2^REFRESH_BITS clk
  parameter int BLANK_CYCLES       = 64,  // anodes-off window per digit period
  parameter bit BLANK_LEADING_ZERO = 1'b1 // dark tens digit for values 0..9
) (
  input  logic       clk,
  input  logic       rst,    // asynchronous, active-low
  input  logic [3:0] count,
  output logic [6:0] seg,    // {g,f,e,d,c,b,a}, active-low
  output logic [1:0] an,     // an[0] = ones digit, an[1] = tens digit
  output logic       dp
);

  // Which digit owns the current refresh period.
  typedef enum logic {
    DIGIT_ONES = 1'b0,
    DIGIT_TENS = 1'b1
  } digit_e;

  localparam logic [REFRESH_BITS-1:0] REF_LAST    = '1;
  localparam logic [REFRESH_BITS-1:0] BLANK_LIMIT = REFRESH_BITS'(BLANK_CYCLES);

  localparam logic [6:0] SEG_OFF   = 7'b1111111;
  localparam logic [1:0] AN_NONE   = 2'b11;
  localparam logic [1:0] AN_ONES   = 2'b10;
  localparam logic [1:0] AN_TENS   = 2'b01;

  // Active-low segment pattern for one decimal digit; anything above 9 is dark.
  function automatic logic [6:0] sseg_pattern(input logic [3:0] digit);
    logic [6:0] pattern;
    case (digit)
      4'd0:    pattern = 7'b1000000;
      4'd1:    pattern = 7'b1111001;
      4'd2:    pattern = 7'b0100100;
      4'd3:    pattern = 7'b0110000;
      4'd4:    pattern = 7'b0011001;
      4'd5:    pattern = 7'b0010010;
      4'd6:    pattern = 7'b0000010;
      4'd7:    pattern = 7'b1111000;
      4'd8:    pattern = 7'b0000000;
      4'd9:    pattern = 7'b0010000;
      default: pattern = SEG_OFF;
    endcase
    return pattern;
  endfunction

  logic [3:0]              sync1;
  logic [3:0]              sync2;
  logic [3:0]              disp_val;
  logic [REFRESH_BITS-1:0] ref_cnt;
  digit_e                  digit_sel;

  logic                    ref_wrap;
  logic                    frame_end;
  logic                    in_blank;
  logic [3:0]              tens;
  logic [3:0]              ones;
  logic [6:0]              seg_next;
  logic [1:0]              an_next;

  // The decimal point is never used.
  assign dp = 1'b1;

  assign ref_wrap  = (ref_cnt == REF_LAST);
  assign frame_end = ref_wrap && (digit_sel == DIGIT_TENS);
  assign in_blank  = (ref_cnt < BLANK_LIMIT);

  // Two-flop synchroniser: count is asynchronous to the frame timing.
  // NOTE: every register here uses <= so all flops sample pre-edge values;
  // a blocking = would let sync2 see this cycle's sync1 and collapse the chain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 4'd0;
      sync2 <= 4'd0;
    end else begin
      sync1 <= count;
      sync2 <= sync1;
    end
  end

  // Refresh counter and digit select; digit_sel flips as ref_cnt wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ref_cnt   <= '0;
      digit_sel <= DIGIT_ONES;
    end else begin
      ref_cnt <= ref_cnt + REFRESH_BITS'(1);
      if (ref_wrap) begin
        digit_sel <= (digit_sel == DIGIT_ONES) ? DIGIT_TENS : DIGIT_ONES;
      end
    end
  end

  // Frame snapshot taken at the end of the tens period, so both digits of a
  // frame always come from the same value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      disp_val <= 4'd0;
    end else if (frame_end) begin
      disp_val <= sync2;
    end
  end

  // Binary 0..15 to two decimal digits; the tens digit is only ever 0 or 1.
  always_comb begin
    tens = 4'd0;
    ones = disp_val;
    if (disp_val >= 4'd10) begin
      tens = 4'd1;
      ones = disp_val - 4'd10;
    end
  end

  // Next segment/anode values for the current period and blanking state.
  // NOTE: defaults first so every path assigns both outputs and no latch forms.
  always_comb begin
    an_next  = AN_NONE;
    seg_next = SEG_OFF;
    if (digit_sel == DIGIT_ONES) begin
      seg_next = sseg_pattern(ones);
      an_next  = AN_ONES;
    end else if (BLANK_LEADING_ZERO && (tens == 4'd0)) begin
      seg_next = SEG_OFF;
      an_next  = AN_NONE;
    end else begin
      seg_next = sseg_pattern(tens);
      an_next  = AN_TENS;
    end
    // The blanking window only gates the anodes; segments keep the digit.
    if (in_blank) begin
      an_next  = AN_NONE;
      seg_next = (digit_sel == DIGIT_ONES) ? sseg_pattern(ones) : sseg_pattern(tens);
    end
  end

  // Output register: glitch-free pins, one clk behind the internal state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg <= SEG_OFF;
      an  <= AN_NONE;
    end else begin
      seg <= seg_next;
      an  <= an_next;
    end
  end

endmodule
